// File: rtl/ifq_buffer_pkg.sv
// Shared types and default sizes for the instruction fetch queue.
// IFQ_PC_W follows the register-bus width, IFQ_INST_W is the instruction
// bus width and IFQ_DEPTH is the default number of queue entries.
package ifq_buffer_pkg;

  localparam int IFQ_PC_W   = 64;
  localparam int IFQ_INST_W = 32;
  localparam int IFQ_DEPTH  = 4;

  // Occupancy class derived purely from the pointer pair; the queue has no
  // other state.
  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_e;

  // Equal index bits mean either empty (same wrap bit) or full (wrap bits differ).
  function automatic occ_e occ_decode(input logic idx_eq, input logic wrap_eq);
    occ_e occ;
    if (idx_eq && wrap_eq) begin
      occ = OCC_EMPTY;
    end else if (idx_eq) begin
      occ = OCC_FULL;
    end else begin
      occ = OCC_PARTIAL;
    end
    return occ;
  endfunction

endpackage

// File: rtl/ifq_buffer_if.sv
// Fetch-side and decode-side handshake bundle for the instruction fetch queue.
// master: the surrounding pipeline (fetch + decode); slave: the queue itself.
interface ifq_buffer_if #(
  parameter int DEPTH  = ifq_buffer_pkg::IFQ_DEPTH,
  parameter int PC_W   = ifq_buffer_pkg::IFQ_PC_W,
  parameter int INST_W = ifq_buffer_pkg::IFQ_INST_W
) ();

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              flush_i;
  logic              in_valid;
  logic [PC_W-1:0]   in_pc;
  logic [INST_W-1:0] in_inst;
  logic              in_ready;
  logic              out_valid;
  logic [PC_W-1:0]   out_pc;
  logic [INST_W-1:0] out_inst;
  logic              out_ready;
  logic [CNT_W-1:0]  count;

  modport master (
    output flush_i, in_valid, in_pc, in_inst, out_ready,
    input  in_ready, out_valid, out_pc, out_inst, count
  );

  modport slave (
    input  flush_i, in_valid, in_pc, in_inst, out_ready,
    output in_ready, out_valid, out_pc, out_inst, count
  );

endinterface

// File: rtl/ifq_buffer_ptr.sv
// ifq_ptr: wrap-bit pointer register for the fetch queue. The MSB is the
// wrap bit; the lower bits index storage. Clear wins over increment.
module ifq_ptr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  // Pointer advance with synchronous clear on redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + W'(1);
    end
  end

endmodule

// File: rtl/ifq_buffer.sv
// ifq_buffer: instruction fetch queue between fetch and decode.
// Circular buffer of {pc, inst} pairs with valid/ready on both sides; a
// flush drops every entry and any same-cycle enqueue.
// Build option IFQ_BYPASS_EN: when the queue is empty an incoming entry is
// presented to decode combinationally, and passes straight through (never
// written) if decode takes it in the same cycle.
module ifq_buffer
  import ifq_buffer_pkg::*;
#(
  parameter int DEPTH  = IFQ_DEPTH,
  parameter int PC_W   = IFQ_PC_W,
  parameter int INST_W = IFQ_INST_W
) (
  input  logic         clk,
  input  logic         rst,
  ifq_buffer_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CW-1:0]     wr_ptr;
  logic [CW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_idx;
  logic [AW-1:0]     rd_idx;
  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  occ_e occ;
  logic empty;
  logic full;
  logic bypass_hit;
  logic pass_thru;
  logic enq;
  logic deq;

  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];
  assign occ    = occ_decode(wr_idx == rd_idx, wr_ptr[AW] == rd_ptr[AW]);
  assign empty  = (occ == OCC_EMPTY);
  assign full   = (occ == OCC_FULL);

`ifdef IFQ_BYPASS_EN
  assign bypass_hit = empty && bus.in_valid && !bus.flush_i;
`else
  assign bypass_hit = 1'b0;
`endif

  // A bypassed entry consumed in the same cycle touches neither pointer.
  assign pass_thru = bypass_hit && bus.out_ready;

  // in_ready ignores out_ready on purpose: a full queue never accepts,
  // which keeps the fetch-side ready free of any decode-side path.
  assign bus.in_ready  = !full;
  assign bus.out_valid = (!empty || bypass_hit) && !bus.flush_i;
  assign bus.count     = wr_ptr - rd_ptr;

  assign enq = bus.in_valid && !full && !bus.flush_i && !pass_thru;
  assign deq = bus.out_valid && bus.out_ready && !pass_thru;

  // Head-of-queue (or bypassed input) presented to decode; zero when idle.
  always_comb begin
    bus.out_pc   = '0;
    bus.out_inst = '0;
    if (bypass_hit) begin
      bus.out_pc   = bus.in_pc;
      bus.out_inst = bus.in_inst;
    end else if (bus.out_valid) begin
      bus.out_pc   = pc_mem[rd_idx];
      bus.out_inst = inst_mem[rd_idx];
    end
  end

  // Entry storage: written on enqueue, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
    end else if (enq) begin
      pc_mem[wr_idx]   <= bus.in_pc;
      inst_mem[wr_idx] <= bus.in_inst;
    end
  end

  ifq_ptr #(.W(CW)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (bus.flush_i),
    .inc (enq),
    .ptr (wr_ptr)
  );

  ifq_ptr #(.W(CW)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (bus.flush_i),
    .inc (deq),
    .ptr (rd_ptr)
  );

endmodule

// File: tb/tb_ifq_buffer.sv
// Self-checking bench for ifq_buffer: a vector table run through a
// queue-based reference model, plus hand-written reset and bypass sequences.
module tb_ifq_buffer;

  localparam int DEPTH  = 4;
  localparam int PC_W   = 64;
  localparam int INST_W = 32;
  localparam logic [63:0] FLUSHED_PC = 64'h8000_0100;

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_errors = 0;
  bit flushed_seen = 0;

  logic [63:0] sb[$];

  typedef struct {
    bit          fl;
    bit          iv;
    logic [63:0] pc;
    bit          ordy;
    int          exp_cnt;
  } vec_t;

  vec_t vecs[$];

  ifq_buffer_if #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W)) bus ();

  ifq_buffer #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [63:0] pc);
    logic [31:0] lo;
    lo = pc[31:0];
    return lo ^ 32'h1357_9BDF;
  endfunction

  function automatic void add(input bit fl, input bit iv, input logic [63:0] pc,
                              input bit ordy, input int exp_cnt);
    vec_t v;
    v.fl = fl; v.iv = iv; v.pc = pc; v.ordy = ordy; v.exp_cnt = exp_cnt;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: drive after negedge, compare against the model
  // before the rising edge, then advance the model on that edge.
  task automatic step(input bit fl, input bit iv, input logic [63:0] pc, input bit ordy);
    bit m_empty, m_full, byp, exp_ov, pass, enq, deq;
    logic [63:0] exp_pc;
    @(negedge clk);
    bus.flush_i   = fl;
    bus.in_valid  = iv;
    bus.in_pc     = pc;
    bus.in_inst   = inst_of(pc);
    bus.out_ready = ordy;
    #1;
    m_empty = (sb.size() == 0);
    m_full  = (sb.size() == DEPTH);
    byp = 1'b0;
`ifdef IFQ_BYPASS_EN
    byp = m_empty && iv && !fl;
`endif
    exp_ov = (!m_empty || byp) && !fl;
    exp_pc = '0;
    if (exp_ov) exp_pc = byp ? pc : sb[0];
    chk("in_ready", 64'(bus.in_ready), 64'(!m_full));
    chk("out_valid", 64'(bus.out_valid), 64'(exp_ov));
    chk("count", 64'(bus.count), 64'(sb.size()));
    chk("out_pc", bus.out_pc, exp_pc);
    chk("out_inst", 64'(bus.out_inst), exp_ov ? 64'(inst_of(exp_pc)) : 64'd0);
    if (bus.out_valid && bus.out_pc == FLUSHED_PC) flushed_seen = 1'b1;
    pass = byp && ordy;
    enq  = iv && !m_full && !fl && !pass;
    deq  = exp_ov && ordy && !pass;
    @(posedge clk);
    if (fl) begin
      sb.delete();
    end else begin
      if (deq) void'(sb.pop_front());
      if (enq) sb.push_back(pc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.flush_i = 1'b0; bus.in_valid = 1'b0; bus.in_pc = '0;
    bus.in_inst = '0; bus.out_ready = 1'b0;
    #2;
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_pc", bus.out_pc, 64'd0);
    chk("rst_out_inst", 64'(bus.out_inst), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset asserted mid-stream with three entries held
    step(0, 1, 64'h8000_0A00, 0);
    step(0, 1, 64'h8000_0A04, 0);
    step(0, 1, 64'h8000_0A08, 0);
    #1;
    chk("pre_rst_count", 64'(bus.count), 64'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_count", 64'(bus.count), 64'd0);
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_out_pc", bus.out_pc, 64'd0);
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    sb.delete();
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(0, 1, 64'h8000_0000, 0);
    #1;
    chk("post_rst_out_valid", 64'(bus.out_valid), 64'd1);
    chk("post_rst_out_pc", bus.out_pc, 64'h8000_0000);
    step(0, 0, 64'd0, 1);
    #1;
    chk("post_rst_drain_count", 64'(bus.count), 64'd0);

    // Fill to full, attempt a fifth, then drain in order
    for (int i = 0; i < 4; i++) add(0, 1, 64'h8000_0000 + 64'(4 * i), 0, i + 1);
    add(0, 1, 64'h8000_0010, 0, 4);
    for (int i = 0; i < 4; i++) add(0, 0, 64'd0, 1, 3 - i);
    // Full with simultaneous enqueue attempt and dequeue
    for (int i = 0; i < 4; i++) add(0, 1, 64'h8000_0020 + 64'(4 * i), 0, i + 1);
    add(0, 1, 64'h8000_0030, 1, 3);
    add(0, 0, 64'd0, 0, 3);
    // Flush with three held and an enqueue in the same cycle
    add(1, 1, FLUSHED_PC, 0, 0);
    add(0, 0, 64'd0, 1, 0);
    // Steady stream at occupancy two, wrapping the pointers
    add(0, 1, 64'h8000_0300, 0, 1);
    add(0, 1, 64'h8000_0304, 0, 2);
    for (int i = 0; i < 10; i++) add(0, 1, 64'h8000_0308 + 64'(4 * i), 1, 2);
    add(0, 0, 64'd0, 1, 1);
    add(0, 0, 64'd0, 1, 0);

    foreach (vecs[k]) begin
      step(vecs[k].fl, vecs[k].iv, vecs[k].pc, vecs[k].ordy);
      #1;
      chk($sformatf("tbl_count[%0d]", k), 64'(bus.count), 64'(vecs[k].exp_cnt));
    end
    chk("flushed_pc_seen", 64'(flushed_seen), 64'd0);

    // Empty queue, entry offered while decode is ready
    @(negedge clk);
    bus.flush_i = 1'b0; bus.in_valid = 1'b1; bus.in_pc = 64'h8000_0200;
    bus.in_inst = inst_of(64'h8000_0200); bus.out_ready = 1'b1;
    #1;
`ifdef IFQ_BYPASS_EN
    chk("byp_out_valid", 64'(bus.out_valid), 64'd1);
    chk("byp_out_pc", bus.out_pc, 64'h8000_0200);
    @(posedge clk);
    #1;
    chk("byp_count", 64'(bus.count), 64'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk("byp_after_out_valid", 64'(bus.out_valid), 64'd0);
`else
    chk("nobyp_out_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("nobyp_count", 64'(bus.count), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk("nobyp_late_out_valid", 64'(bus.out_valid), 64'd1);
    chk("nobyp_late_out_pc", bus.out_pc, 64'h8000_0200);
    @(posedge clk);
    #1;
    chk("nobyp_drained_count", 64'(bus.count), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ifq_buffer.md
Name: ifq_buffer

Overview:
- Instruction fetch queue between the fetch stage (PC generation plus instruction memory response) and the decode stage.
- Holds up to DEPTH {pc, inst} pairs in a circular buffer, with a valid/ready handshake on both sides.
- Back-pressures fetch when full.
- Discards all contents on a pipeline redirect (flush), so decode never sees wrong-path instructions.

Parameters:
- DEPTH, 4: number of entries; power of two, minimum 2.
- PC_W, 64: PC width; matches the register bus width.
- INST_W, 32: instruction width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- flush_i  in  1  redirect; drops all entries and any same-cycle enqueue.
- in_valid  in  1  fetch presents a valid {in_pc, in_inst}.
- in_pc  in  PC_W  PC of the presented instruction.
- in_inst  in  INST_W  presented instruction word.
- in_ready  out  1  queue accepts an enqueue this cycle.
- out_valid  out  1  head entry is valid for decode.
- out_pc  out  PC_W  PC of the head entry.
- out_inst  out  INST_W  instruction word of the head entry.
- out_ready  in  1  decode consumes the head this cycle.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Handshake events:
  - enq = in_valid && in_ready && !flush_i.
  - deq = out_valid && out_ready.
- Pointers:
  - wr_ptr and rd_ptr are each $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = index bits equal and wrap bits differ.
  - count = wr_ptr - rd_ptr, computed modulo 2^($clog2(DEPTH)+1).
- Flow control:
  - in_ready = !full. It is combinational and does not depend on out_ready: a full queue accepts nothing, even when a dequeue occurs in the same cycle.
  - out_valid = !empty && !flush_i.
  - out_pc and out_inst = storage[rd_ptr index] when out_valid; otherwise all zero.
- Latency: without bypass, an enqueued entry is visible at the output on the next cycle (1 cycle).
- Enqueue: writes storage[wr_ptr index]; wr_ptr increments and wraps naturally via the wrap bit.
- Dequeue: rd_ptr increments.
- Simultaneous enqueue and dequeue (not full, not empty): both pointers advance; count is unchanged.
- Empty with enqueue only: count goes 0 -> 1; out_valid rises on the next cycle.
- Full with dequeue: count goes DEPTH -> DEPTH-1; in_ready rises on the next cycle.
- Flush:
  - Highest priority.
  - In the flush cycle, out_valid = 0, no deq is counted, and any enq is dropped.
  - On the next edge, wr_ptr = rd_ptr = 0 and count = 0.
- Reset (asserted at any time, including mid-operation):
  - Pointers and all storage clear to 0 asynchronously.
  - out_valid = 0, out_pc = 0, out_inst = 0, count = 0, in_ready = 1.
  - After rst deasserts, the queue is empty and ready.
- State machine: none beyond the pointer pair. Occupancy fully defines the state: EMPTY, PARTIAL or FULL, derived from the pointers.

Optional Feature:
- Macro: IFQ_BYPASS_EN.
- Defined:
  - When the queue is empty, in_valid = 1 and flush_i = 0, the output is driven combinationally from the input: out_valid = 1, out_pc = in_pc, out_inst = in_inst.
  - If out_ready is also high, the entry passes through without being written: pointers unchanged, count stays 0, latency 0.
  - If out_ready is low, the entry is enqueued normally.
- Undefined: no combinational path from in_* to out_*; minimum latency is 1 cycle.

Decomposition:
- Shared defines file (already included codebase-wide) holds:
  - PC width, via the existing register-bus width macro.
  - A new INST_BUS width macro.
  - A new IFQ_DEPTH default.
- One sub-module, ifq_ptr: a wrap-bit pointer register with async reset, increment enable and synchronous clear. Instantiated twice, for the read and write pointers.

Test Plan:
1. rst=1 mid-stream with count=3 -> immediately count=0, out_valid=0, out_pc=0, in_ready=1; after release, first enqueue of pc=0x80000000 appears next cycle.
2. Enqueue 4 entries (pc 0x80000000..0x8000000C) with out_ready=0 -> in_ready=0, count=4; a fifth in_valid is not accepted; then out_ready=1 -> entries drained in order, count 4->0.
3. Steady stream with in_valid=1 and out_ready=1 at count=2 for 10 cycles -> count stays 2, PCs in strict +4 order, pointers wrap past index 3 without loss.
4. flush_i=1 with count=3 and in_valid=1 (pc 0x80000100) -> out_valid=0 that cycle; next cycle count=0 and pc 0x80000100 never appears at the output.
5. Full with out_ready=1 and in_valid=1 in the same cycle -> only the dequeue occurs, count=3, in_ready=1 on the next cycle.
6. With IFQ_BYPASS_EN: empty queue, in_valid=1, in_pc=0x80000200, out_ready=1 -> out_valid=1 and out_pc=0x80000200 in the same cycle, count remains 0. Without the macro: out_valid=1 one cycle later.
